// File: rtl/obstacle_collision_scorer.sv
// obstacle_collision_scorer
// Samples obstacle and player boxes once per frame tick, tests them for
// overlap and keeps hit / lives / invulnerability / game-over / BCD score.
module obstacle_collision_scorer #(
  parameter int PLAYER_W     = 16,
  parameter int PLAYER_H     = 32,
  parameter int OBS_W        = 16,
  parameter int OBS_H        = 16,
  parameter int LIVES        = 3,
  parameter int INVULN_TICKS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        update,
  input  logic [7:0]  xObstacle,
  input  logic [8:0]  yObstacle,
  input  logic [3:0]  obstacleId,
  input  logic        passed,
  input  logic [7:0]  xPlayer,
  input  logic [8:0]  yPlayer,
  output logic        hit,
  output logic [1:0]  lives,
  output logic        invulnerable,
  output logic        gameOver,
  output logic [15:0] score
);

  // state     | meaning
  // S_IDLE    | waiting for a frame tick; captures inputs on it
  // S_TEST    | registers the box overlap of the captured inputs
  // S_RESOLVE | applies invulnerability, collision and score updates
  // S_GAMEOVER| lives exhausted; everything frozen until reset
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TEST     = 2'd1,
    S_RESOLVE  = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  state_t      state_q;
  logic        upd_s1_q, upd_s2_q, upd_s3_q;
  logic        tick;
  logic [7:0]  xo_q, xp_q;
  logic [8:0]  yo_q, yp_q;
  logic [3:0]  id_q;
  logic        passed_q;
  logic        overlap_q, overlap_d;
  logic [7:0]  cnt_q;
  logic        obs_hit_q;
  logic [1:0]  lives_q;
  logic [15:0] score_q, score_inc_d;
  logic        hit_q;
  logic        hit_now, score_en;
  logic        carry;
  logic [9:0]  xo_end, xp_end, yo_end, yp_end;
  logic        id_valid;

  // Two-flop synchroniser for the asynchronous update net plus edge flop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upd_s1_q <= 1'b0;
      upd_s2_q <= 1'b0;
      upd_s3_q <= 1'b0;
    end else begin
      upd_s1_q <= update;
      upd_s2_q <= upd_s1_q;
      upd_s3_q <= upd_s2_q;
    end
  end

  assign tick = upd_s2_q & ~upd_s3_q;

  // Axis-aligned overlap on the captured boxes; 10-bit sums so the far edge never wraps
  always_comb begin
    xo_end    = {2'b00, xo_q} + 10'(OBS_W);
    xp_end    = {2'b00, xp_q} + 10'(PLAYER_W);
    yo_end    = {1'b0, yo_q} + 10'(OBS_H);
    yp_end    = {1'b0, yp_q} + 10'(PLAYER_H);
    id_valid  = (id_q == 4'd6) || (id_q == 4'd7) || (id_q == 4'd8);
    overlap_d = id_valid &&
                ({2'b00, xp_q} < xo_end) && ({2'b00, xo_q} < xp_end) &&
                ({1'b0, yp_q} < yo_end) && ({1'b0, yo_q} < yp_end);
  end

  // Resolve decisions: collision only when not invulnerable; a hit obstacle never scores
  always_comb begin
    hit_now  = overlap_q && (cnt_q == 8'd0);
    score_en = passed_q && !(obs_hit_q || hit_now);
  end

  // BCD +1 with per-digit carry; 9999 rolls over to 0000
  always_comb begin
    score_inc_d = score_q;
    carry       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc_d[4*i +: 4] = 4'd0;
        end else begin
          score_inc_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Sequencer: capture, test, resolve, with registered hit pulse and game state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      xo_q      <= 8'd0;
      xp_q      <= 8'd0;
      yo_q      <= 9'd0;
      yp_q      <= 9'd0;
      id_q      <= 4'd0;
      passed_q  <= 1'b0;
      overlap_q <= 1'b0;
      cnt_q     <= 8'd0;
      obs_hit_q <= 1'b0;
      lives_q   <= 2'(LIVES);
      score_q   <= 16'h0000;
      hit_q     <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            xo_q     <= xObstacle;
            yo_q     <= yObstacle;
            id_q     <= obstacleId;
            passed_q <= passed;
            xp_q     <= xPlayer;
            yp_q     <= yPlayer;
            state_q  <= S_TEST;
          end
        end
        S_TEST: begin
          overlap_q <= overlap_d;
          state_q   <= S_RESOLVE;
        end
        S_RESOLVE: begin
          if (hit_now) begin
            hit_q   <= 1'b1;
            lives_q <= lives_q - 2'd1;
            cnt_q   <= 8'(INVULN_TICKS);
          end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end
          if (score_en) begin
            score_q <= score_inc_d;
          end
          if (passed_q) begin
            obs_hit_q <= 1'b0;
          end else if (hit_now) begin
            obs_hit_q <= 1'b1;
          end
          state_q <= (hit_now && lives_q == 2'd1) ? S_GAMEOVER : S_IDLE;
        end
        S_GAMEOVER: begin
          state_q <= S_GAMEOVER;
        end
      endcase
    end
  end

  assign hit          = hit_q;
  assign lives        = lives_q;
  assign invulnerable = (cnt_q != 8'd0);
  assign gameOver     = (state_q == S_GAMEOVER);
  assign score        = score_q;

endmodule

// File: tb/tb_obstacle_collision_scorer.sv
// Scoreboard bench for obstacle_collision_scorer: stimulus pushes expected
// post-resolve outputs from a frame-level model; a monitor pops and compares.
module tb_obstacle_collision_scorer;

  localparam int PW = 16, PH = 32, OW = 16, OH = 16, NL = 3, NI = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [7:0]  xObstacle = 8'd0, xPlayer = 8'd0;
  logic [8:0]  yObstacle = 9'd0, yPlayer = 9'd0;
  logic [3:0]  obstacleId = 4'd0;
  logic        passed = 1'b0;
  logic        hit, invulnerable, gameOver;
  logic [1:0]  lives;
  logic [15:0] score;

  obstacle_collision_scorer #(
    .PLAYER_W(PW), .PLAYER_H(PH), .OBS_W(OW), .OBS_H(OH),
    .LIVES(NL), .INVULN_TICKS(NI)
  ) dut (
    .clock(clock), .reset(reset), .update(update),
    .xObstacle(xObstacle), .yObstacle(yObstacle), .obstacleId(obstacleId),
    .passed(passed), .xPlayer(xPlayer), .yPlayer(yPlayer),
    .hit(hit), .lives(lives), .invulnerable(invulnerable),
    .gameOver(gameOver), .score(score)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        hit;
    logic [1:0]  lives;
    logic        inv;
    logic        go;
    logic [15:0] score;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // frame-level game model
  int m_lives, m_inv, m_score;
  bit m_obs_hit, m_go;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_lives = NL; m_inv = 0; m_score = 0; m_obs_hit = 0; m_go = 0;
  endtask

  function automatic exp_t model_now(input bit h);
    exp_t e;
    e.hit = h; e.lives = 2'(m_lives); e.inv = (m_inv != 0);
    e.go = m_go; e.score = to_bcd(m_score);
    return e;
  endfunction

  task automatic model_tick(input int xo, input int yo, input int id, input bit ps,
                            input int xp, input int yp);
    bit ov, h;
    int inv_entry;
    h = 0;
    if (!m_go) begin
      ov = (id == 6 || id == 7 || id == 8) &&
           (xp < xo + OW) && (xo < xp + PW) && (yp < yo + OH) && (yo < yp + PH);
      inv_entry = m_inv;
      if (m_inv > 0) m_inv--;
      if (ov && inv_entry == 0) begin
        h = 1; m_lives--; m_inv = NI; m_obs_hit = 1;
      end
      if (ps) begin
        if (!m_obs_hit) m_score = (m_score + 1) % 10000;
        m_obs_hit = 0;
      end
      if (m_lives == 0) m_go = 1;
    end
    exp_q.push_back(model_now(h));
  endtask

  task automatic do_tick(input int xo, input int yo, input int id, input bit ps,
                         input int xp, input int yp);
    @(negedge clock);
    xObstacle = 8'(xo); yObstacle = 9'(yo); obstacleId = 4'(id); passed = ps;
    xPlayer = 8'(xp); yPlayer = 9'(yp);
    model_tick(xo, yo, id, ps, xp, yp);
    update = 1'b1;
    repeat (4) @(negedge clock);
    update = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hit"}, {15'd0, hit}, 16'd0);
    check({tag, "_lives"}, {14'd0, lives}, 16'(NL));
    check({tag, "_inv"}, {15'd0, invulnerable}, 16'd0);
    check({tag, "_go"}, {15'd0, gameOver}, 16'd0);
    check({tag, "_score"}, score, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check_reset_vals("reset");
  endtask

  // monitor: outputs of a frame are due five clocks after update rises
  initial begin
    exp_t e;
    forever begin
      @(posedge update);
      repeat (4) @(posedge clock);
      #1 check("hit_early", {15'd0, hit}, 16'd0);
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL queue_empty actual=0 entries required=1 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("hit", {15'd0, hit}, {15'd0, e.hit});
        check("lives", {14'd0, lives}, {14'd0, e.lives});
        check("invulnerable", {15'd0, invulnerable}, {15'd0, e.inv});
        check("gameOver", {15'd0, gameOver}, {15'd0, e.go});
        check("score", score, e.score);
      end
      @(posedge clock);
      #1 check("hit_width", {15'd0, hit}, 16'd0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int ids[6] = '{0, 6, 7, 8, 9, 15};

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("init");

    // no collision, then passed scores
    do_tick(63, 419, 6, 0, 10, 100);
    do_tick(63, 419, 6, 1, 10, 100);

    // collision, then passed on the hit obstacle does not score
    do_tick(63, 419, 6, 0, 60, 410);
    do_tick(63, 419, 6, 1, 60, 410);

    // hold overlap through invulnerability until the next hit
    for (int i = 0; i < 17; i++) do_tick(63, 419, 7, 0, 60, 410);

    // edges, invalid IDs, far-edge no-wrap, BCD wrap
    do_reset();
    do_tick(63, 419, 6, 0, 79, 410);   // player left edge touches obstacle right edge
    do_tick(63, 419, 6, 0, 47, 410);   // obstacle left edge touches player right edge
    do_tick(63, 419, 6, 0, 60, 435);   // y touching below
    do_tick(63, 419, 6, 0, 60, 387);   // y touching above
    do_tick(63, 419, 0, 0, 63, 419);   // id 0 full overlap
    do_tick(63, 419, 9, 0, 63, 419);   // id 9 full overlap
    do_tick(250, 500, 8, 0, 255, 505); // overlap near coordinate limits
    do_tick(63, 419, 6, 1, 10, 100);
    do_tick(63, 419, 6, 1, 10, 100);
    @(negedge clock);
    force dut.score_q = 16'h9999;
    @(negedge clock);
    release dut.score_q;
    m_score = 9999;
    do_tick(63, 419, 6, 1, 10, 100);

    // three spaced hits to game over, then frozen
    do_reset();
    for (int k = 0; k < 3; k++) begin
      do_tick(63, 419, 6, 0, 60, 410);
      if (k < 2) for (int i = 0; i < 16; i++) do_tick(63, 419, 6, 0, 10, 100);
    end
    for (int i = 0; i < 3; i++) do_tick(63, 419, 8, 1, 60, 410);

    // reset during the TEST cycle of a colliding tick
    do_reset();
    @(negedge clock);
    xObstacle = 8'd63; yObstacle = 9'd419; obstacleId = 4'd6; passed = 1'b0;
    xPlayer = 8'd60; yPlayer = 9'd410;
    update = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    exp_q.push_back(model_now(0));
    @(negedge clock);
    update = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_reset_vals("midreset");
    do_tick(63, 419, 6, 0, 60, 410);

    // randomized frames
    do_reset();
    for (int i = 0; i < 60; i++) begin
      do_tick($urandom_range(40, 120), $urandom_range(380, 450),
              ids[$urandom_range(0, 5)], ($urandom_range(0, 2) == 0),
              $urandom_range(40, 120), $urandom_range(360, 460));
    end

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
